dcache_flush_ctrl: RTL and testbench
====================================

# dcache_flush_ctrl

Miss handler and refill/write-back sequencer for the data cache. Watches the per-line hit/miss status of all `dcache_line` instances, picks a victim line on a global miss, writes it back to memory if dirty, then refills it word by word. It sits between the line array and the memory port, and drives the lines' `flush_*`, `line_in` and `line_in_valid` inputs.

## Interface
- `DATABITS`, 32, word width
- `ADDRBITS`, 32, byte address width
- `CACHEADDRBITS`, 5, word index bits per line (`CACHESIZE=2**CACHEADDRBITS` words)
- `LSBITS`, 2, byte-in-word bits
- `LINENUM`, 4, number of cache lines
- `CNTMISSBITS`, 8, width of each line's miss counter

Ports:
- `clk`  in  1  clock; one clock domain
- `reset_n`  in  1  synchronous, active-low reset
- `dcache_addr`  in  ADDRBITS  address of the pending access
- `dcache_rdreq`, `dcache_wrreq`  in  1  pending read/write
- `line_miss_all`  in  LINENUM  per-line `line_miss`
- `line_valid_all`  in  LINENUM  per-line `line_valid`
- `line_dirty_all`  in  LINENUM  per-line `line_dirty`
- `cnt_miss_all`  in  LINENUM*CNTMISSBITS  per-line `flush_cnt_miss`; line i at bits [i*CNTMISSBITS +: CNTMISSBITS]
- `line_addr_all`  in  LINENUM*ADDRBITS  per-line `mem_addr` (current base address)
- `line_out_all`  in  LINENUM*DATABITS  per-line `line_out`
- `flush_mode`  out  LINENUM  one-hot victim select
- `flush_write`, `flush_dirty`  out  1  shared to all lines
- `flush_addr`  out  CACHEADDRBITS  word index being flushed
- `line_in`  out  DATABITS  refill data
- `line_in_valid`  out  1  refill data strobe
- `flush_busy`  out  1  miss handling in progress
- `mem_addr`  out  ADDRBITS  word-aligned memory address
- `mem_out`  out  DATABITS  write-back data
- `mem_wrreq`, `mem_rdreq`  out  1  held until acknowledged
- `mem_ack`  in  1  write accepted
- `mem_in`  in  DATABITS  read data
- `mem_in_valid`  in  1  read data valid, completes a read

## Operation
- Global miss: `(dcache_rdreq|dcache_wrreq) & (&line_miss_all)`, sampled only in IDLE.
- States: IDLE, SELECT, WB_RD, WB_WR, FILL_REQ, FILL_WR, DONE.
- IDLE + miss -> SELECT. Latch `dcache_addr`, and `flush_dirty<=dcache_wrreq`.
- SELECT chooses the victim:
  - lowest-index line with `line_valid=0`;
  - otherwise the line with the highest miss count, ties going to the lowest index.
  - Latch the victim's one-hot, its base address and its dirty bit. Set index i=0.
  - Next state: dirty -> WB_RD, else FILL_REQ.
- WB_RD: `flush_addr=i`, `flush_write=0`. After one cycle, `mem_out<=line_out` of the victim -> WB_WR.
- WB_WR: `mem_wrreq=1`, `mem_addr={victim_base[ADDRBITS-1:CACHEADDRBITS+LSBITS], i, 2'b00}`, held until `mem_ack`. Then i++. If i wraps to 0 -> FILL_REQ, else WB_RD.
- FILL_REQ: `mem_rdreq=1`, `mem_addr={req_addr tag, i, 00}`, held until `mem_in_valid`. Capture `mem_in` -> FILL_WR.
- FILL_WR: one-cycle pulse of `line_in=captured`, `line_in_valid=1`, `flush_write=1`, `flush_addr=i`. Then i++. If i wraps -> DONE, else FILL_REQ.
- DONE: one cycle with `flush_mode` still asserted, then everything clears -> IDLE.
- `flush_mode` and `flush_busy` are high from the SELECT exit through DONE. `flush_dirty` is held for the same span.
- The index counter is CACHEADDRBITS wide and wraps naturally.
- Requests dropped mid-flush are ignored: the sequence always completes.
- `mem_ack`/`mem_in_valid` outside the matching state are ignored.

## Timing
- Reset (`reset_n=0` at a clk edge): state IDLE, i=0. All outputs are 0: `flush_mode`, `flush_write`, `flush_dirty`, `flush_addr`, `line_in`, `line_in_valid`, `flush_busy`, `mem_*`.
- Reset mid-flush aborts immediately. There is no write-back completion.
- Miss detect -> `flush_busy` is high 1 cycle later (SELECT), and `flush_mode` is high 2 cycles later.
- Minimum clean refill, with `mem_in_valid` in the cycle after `mem_rdreq`: 1 (SELECT) + CACHESIZE*(2+1) + 1 (DONE) cycles.
- Write-back adds CACHESIZE*(1+1+ack latency) cycles.
- `mem_rdreq` and `mem_wrreq` are never high together.
- `mem_addr` is stable while a request is high.

## Test plan
- Clean refill: all lines invalid, rdreq at 0x0000_1234, `mem_in`=0xA5000000+i with 1-cycle latency.
  -> victim line 0; 32 `line_in_valid` pulses with `flush_addr` 0..31 and data matching.
  -> mem_addr 0x1200..0x127C; busy clears; `flush_dirty=0`.
- Victim by counter: all valid, counts {3,9,9,1}, wrreq. -> `flush_mode`=4'b0010, `flush_dirty=1`.
- Dirty write-back: victim line 2 dirty, base 0x8000, line_out=word index.
  -> 32 `mem_wrreq` at 0x8000..0x807C with data 0..31, before the first `mem_rdreq`.
- Back-pressure: `mem_ack` delayed 5 cycles per word. -> `mem_wrreq` and `mem_addr` held stable; no skipped index.
- Reset at the 10th refill word. -> next cycle all outputs are 0; a new miss restarts at i=0.
- Hit (one `line_miss`=0) with rdreq. -> no `flush_busy`, no memory traffic.

Source files
------------

// File: rtl/dcache_flush_ctrl.sv
// dcache_flush_ctrl
//   Miss handler and refill/write-back sequencer for the data cache. On a miss
//   in every line it picks a victim, writes the victim back word by word if it
//   is dirty, then refills it word by word from memory.
//
// Ports
//   clk, reset_n        clock, synchronous active-low reset
//   dcache_addr         address of the pending access
//   dcache_rdreq/wrreq  pending read / write
//   line_*_all          per-line status vectors (miss, valid, dirty, miss
//                       count, base address, read-out data), line i in slice i
//   flush_mode          one-hot victim select to the lines
//   flush_write         write strobe to the victim line (refill)
//   flush_dirty         refill is on behalf of a write
//   flush_addr          word index inside the victim line
//   line_in/_valid      refill word and its strobe
//   flush_busy          miss handling in progress
//   mem_addr/out        word-aligned memory address / write-back data
//   mem_wrreq/rdreq     memory requests, held until mem_ack / mem_in_valid
//   mem_ack             write accepted
//   mem_in/_valid       read data, valid completes the read
module dcache_flush_ctrl #(
    parameter int DATABITS      = 32,
    parameter int ADDRBITS      = 32,
    parameter int CACHEADDRBITS = 5,
    parameter int LSBITS        = 2,
    parameter int LINENUM       = 4,
    parameter int CNTMISSBITS   = 8
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic [ADDRBITS-1:0]             dcache_addr,
    input  logic                            dcache_rdreq,
    input  logic                            dcache_wrreq,
    input  logic [LINENUM-1:0]              line_miss_all,
    input  logic [LINENUM-1:0]              line_valid_all,
    input  logic [LINENUM-1:0]              line_dirty_all,
    input  logic [LINENUM*CNTMISSBITS-1:0]  cnt_miss_all,
    input  logic [LINENUM*ADDRBITS-1:0]     line_addr_all,
    input  logic [LINENUM*DATABITS-1:0]     line_out_all,
    output logic [LINENUM-1:0]              flush_mode,
    output logic                            flush_write,
    output logic                            flush_dirty,
    output logic [CACHEADDRBITS-1:0]        flush_addr,
    output logic [DATABITS-1:0]             line_in,
    output logic                            line_in_valid,
    output logic                            flush_busy,
    output logic [ADDRBITS-1:0]             mem_addr,
    output logic [DATABITS-1:0]             mem_out,
    output logic                            mem_wrreq,
    output logic                            mem_rdreq,
    input  logic                            mem_ack,
    input  logic [DATABITS-1:0]             mem_in,
    input  logic                            mem_in_valid
);

    localparam int IDXW   = (LINENUM > 1) ? $clog2(LINENUM) : 1;
    localparam int TAGLSB = CACHEADDRBITS + LSBITS;

    typedef enum logic [2:0] {
        IDLE, SELECT, WB_RD, WB_WR, FILL_REQ, FILL_WR, DONE
    } state_t;

    state_t                   state, state_next;
    logic [CACHEADDRBITS-1:0] idx;
    logic [ADDRBITS-1:0]      req_addr;
    logic [ADDRBITS-1:0]      victim_base;
    logic [IDXW-1:0]          victim_idx;
    logic [LINENUM-1:0]       victim_oh;
    logic                     dirty_req;
    logic [DATABITS-1:0]      wb_data;
    logic [DATABITS-1:0]      fill_data;

    logic                     global_miss;
    logic                     idx_last;
    logic [IDXW-1:0]          sel_idx;
    logic                     sel_dirty;

    assign global_miss = (dcache_rdreq | dcache_wrreq) & (&line_miss_all);
    assign idx_last    = &idx;

    // Victim choice: lowest-index invalid line wins outright; otherwise the
    // highest miss count, with a strict compare so ties keep the lower index.
    always_comb begin
        logic                   found_invalid;
        logic [IDXW-1:0]        inv_idx;
        logic [IDXW-1:0]        best_idx;
        logic [CNTMISSBITS-1:0] best_cnt;
        // NOTE: every variable gets a default before any branch so the block
        // stays purely combinational and no latch is inferred.
        found_invalid = 1'b0;
        inv_idx       = '0;
        best_idx      = '0;
        best_cnt      = cnt_miss_all[0 +: CNTMISSBITS];
        for (int i = LINENUM - 1; i >= 0; i--) begin
            if (!line_valid_all[i]) begin
                found_invalid = 1'b1;
                inv_idx       = IDXW'(i);
            end
        end
        for (int i = 1; i < LINENUM; i++) begin
            if (cnt_miss_all[i*CNTMISSBITS +: CNTMISSBITS] > best_cnt) begin
                best_cnt = cnt_miss_all[i*CNTMISSBITS +: CNTMISSBITS];
                best_idx = IDXW'(i);
            end
        end
        sel_idx   = found_invalid ? inv_idx : best_idx;
        sel_dirty = line_dirty_all[sel_idx];
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (global_miss) state_next = SELECT;
            SELECT:   state_next = sel_dirty ? WB_RD : FILL_REQ;
            WB_RD:    state_next = WB_WR;
            WB_WR:    if (mem_ack) state_next = idx_last ? FILL_REQ : WB_RD;
            FILL_REQ: if (mem_in_valid) state_next = FILL_WR;
            FILL_WR:  state_next = idx_last ? DONE : FILL_REQ;
            DONE:     state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_comb begin
        flush_write   = 1'b0;
        flush_addr    = '0;
        line_in       = '0;
        line_in_valid = 1'b0;
        mem_addr      = '0;
        mem_wrreq     = 1'b0;
        mem_rdreq     = 1'b0;
        case (state)
            WB_RD: flush_addr = idx;
            WB_WR: begin
                mem_wrreq = 1'b1;
                mem_addr  = {victim_base[ADDRBITS-1:TAGLSB], idx, {LSBITS{1'b0}}};
            end
            FILL_REQ: begin
                mem_rdreq = 1'b1;
                mem_addr  = {req_addr[ADDRBITS-1:TAGLSB], idx, {LSBITS{1'b0}}};
            end
            FILL_WR: begin
                line_in       = fill_data;
                line_in_valid = 1'b1;
                flush_write   = 1'b1;
                flush_addr    = idx;
            end
            default: ;
        endcase
    end

    assign flush_busy  = (state != IDLE);
    assign flush_mode  = victim_oh;
    assign flush_dirty = dirty_req;
    assign mem_out     = wb_data;

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            idx         <= '0;
            req_addr    <= '0;
            victim_base <= '0;
            victim_idx  <= '0;
            victim_oh   <= '0;
            dirty_req   <= 1'b0;
            wb_data     <= '0;
            fill_data   <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: if (global_miss) begin
                    req_addr  <= dcache_addr;
                    dirty_req <= dcache_wrreq;
                end
                SELECT: begin
                    victim_idx  <= sel_idx;
                    victim_oh   <= LINENUM'(1) << sel_idx;
                    victim_base <= line_addr_all[sel_idx*ADDRBITS +: ADDRBITS];
                    idx         <= '0;
                end
                WB_RD:    wb_data <= line_out_all[victim_idx*DATABITS +: DATABITS];
                WB_WR:    if (mem_ack) idx <= idx + 1'b1;
                FILL_REQ: if (mem_in_valid) fill_data <= mem_in;
                FILL_WR:  idx <= idx + 1'b1;
                DONE: begin
                    victim_oh <= '0;
                    dirty_req <= 1'b0;
                    wb_data   <= '0;
                    fill_data <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_flush_ctrl.sv
// Self-checking bench for dcache_flush_ctrl. Expected memory writes, memory
// reads and line refills are queued when a miss is launched and compared as
// the DUT produces them; a negedge-driven memory model answers requests.
module tb_dcache_flush_ctrl;
    localparam int DATABITS = 32, ADDRBITS = 32, CACHEADDRBITS = 5, LSBITS = 2;
    localparam int LINENUM = 4, CNTMISSBITS = 8;

    logic                           clk = 1'b0;
    logic                           reset_n;
    logic [ADDRBITS-1:0]            dcache_addr;
    logic                           dcache_rdreq, dcache_wrreq;
    logic [LINENUM-1:0]             line_miss_all, line_valid_all, line_dirty_all;
    logic [LINENUM*CNTMISSBITS-1:0] cnt_miss_all;
    logic [LINENUM*ADDRBITS-1:0]    line_addr_all;
    logic [LINENUM*DATABITS-1:0]    line_out_all;
    logic [LINENUM-1:0]             flush_mode;
    logic                           flush_write, flush_dirty;
    logic [CACHEADDRBITS-1:0]       flush_addr;
    logic [DATABITS-1:0]            line_in;
    logic                           line_in_valid, flush_busy;
    logic [ADDRBITS-1:0]            mem_addr;
    logic [DATABITS-1:0]            mem_out;
    logic                           mem_wrreq, mem_rdreq, mem_ack;
    logic [DATABITS-1:0]            mem_in;
    logic                           mem_in_valid;

    dcache_flush_ctrl dut (
        .clk(clk), .reset_n(reset_n), .dcache_addr(dcache_addr),
        .dcache_rdreq(dcache_rdreq), .dcache_wrreq(dcache_wrreq),
        .line_miss_all(line_miss_all), .line_valid_all(line_valid_all),
        .line_dirty_all(line_dirty_all), .cnt_miss_all(cnt_miss_all),
        .line_addr_all(line_addr_all), .line_out_all(line_out_all),
        .flush_mode(flush_mode), .flush_write(flush_write), .flush_dirty(flush_dirty),
        .flush_addr(flush_addr), .line_in(line_in), .line_in_valid(line_in_valid),
        .flush_busy(flush_busy), .mem_addr(mem_addr), .mem_out(mem_out),
        .mem_wrreq(mem_wrreq), .mem_rdreq(mem_rdreq), .mem_ack(mem_ack),
        .mem_in(mem_in), .mem_in_valid(mem_in_valid)
    );

    always #5 clk = ~clk;

    // Line read-out model: line 2 returns its word index, others a marker.
    always_comb begin
        for (int l = 0; l < LINENUM; l++)
            line_out_all[l*DATABITS +: DATABITS] = (l == 2) ? {27'd0, flush_addr}
                                                            : (32'hDEAD_0000 | {27'd0, flush_addr});
    end

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } xfer_t;

    xfer_t       exp_wr[$];
    xfer_t       exp_fill[$];
    logic [31:0] exp_rd[$];

    int          n_vec = 0;
    int          n_err = 0;
    int          ack_delay = 0;
    int          fill_cnt = 0;
    int          wr_wait = 0;
    int          rd_wait = 0;
    logic        rd_seen = 1'b0;
    logic [31:0] wr_hold, rd_hold;
    logic [3:0]  cur_mode = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_fill(input logic [31:0] a);
        for (int i = 0; i < 32; i++) begin
            exp_rd.push_back({a[31:7], 5'(i), 2'b00});
            exp_fill.push_back('{addr: 32'(i), data: 32'hA500_0000 + 32'(i)});
        end
    endtask

    task automatic push_wb(input logic [31:0] base);
        for (int i = 0; i < 32; i++)
            exp_wr.push_back('{addr: {base[31:7], 5'(i), 2'b00}, data: 32'(i)});
    endtask

    // Memory model and output monitor, evaluated away from the active edge.
    always @(negedge clk) begin
        xfer_t       x;
        logic [31:0] ra;
        mem_ack      = 1'b0;
        mem_in_valid = 1'b0;
        if (!flush_busy) begin
            wr_wait  = 0;
            rd_wait  = 0;
            rd_seen  = 1'b0;
            fill_cnt = 0;
        end
        if (mem_rdreq && mem_wrreq) check("rd_wr_exclusive", 1, 0);
        if (mem_wrreq) begin
            if (wr_wait == 0) wr_hold = mem_addr;
            else check("wr_addr_stable", mem_addr, wr_hold);
            if (wr_wait == ack_delay) begin
                mem_ack = 1'b1;
                wr_wait = 0;
                check("wb_before_fill", rd_seen, 0);
                if (exp_wr.size() == 0) check("wr_unexpected", 1, 0);
                else begin
                    x = exp_wr.pop_front();
                    check("wr_addr", mem_addr, x.addr);
                    check("wr_data", mem_out, x.data);
                end
            end else wr_wait++;
        end
        if (mem_rdreq) begin
            if (rd_wait == 0) begin
                rd_wait = 1;
                rd_hold = mem_addr;
            end else begin
                check("rd_addr_stable", mem_addr, rd_hold);
                mem_in_valid = 1'b1;
                mem_in       = 32'hA500_0000 + {27'd0, mem_addr[6:2]};
                rd_seen      = 1'b1;
                rd_wait      = 0;
                if (exp_rd.size() == 0) check("rd_unexpected", 1, 0);
                else begin
                    ra = exp_rd.pop_front();
                    check("rd_addr", mem_addr, ra);
                end
            end
        end
        if (line_in_valid) begin
            fill_cnt++;
            check("fill_write", flush_write, 1);
            check("fill_mode", flush_mode, cur_mode);
            if (exp_fill.size() == 0) check("fill_unexpected", 1, 0);
            else begin
                x = exp_fill.pop_front();
                check("fill_addr", flush_addr, x.addr);
                check("fill_data", line_in, x.data);
            end
        end
    end

    task automatic launch(input logic rd, input logic wr, input logic [31:0] a);
        @(negedge clk);
        line_miss_all = '1;
        dcache_addr   = a;
        dcache_rdreq  = rd;
        dcache_wrreq  = wr;
        @(posedge clk);
        #1;
        check("busy_latency", flush_busy, 1);
        check("mode_latency", flush_mode, 0);
        dcache_rdreq = 1'b0;
        dcache_wrreq = 1'b0;
    endtask

    task automatic run_miss(input logic rd, input logic wr, input logic [31:0] a,
                            input logic [3:0] exp_mode, input logic exp_dirty, input int exp_cycles);
        int n;
        cur_mode = exp_mode;
        launch(rd, wr, a);
        @(posedge clk);
        #1;
        check("victim_mode", flush_mode, exp_mode);
        check("flush_dirty", flush_dirty, exp_dirty);
        n = 2;
        while (n < 2000) begin
            @(posedge clk);
            #1;
            if (!flush_busy) break;
            n++;
        end
        if (n >= 2000) check("busy_timeout", 1, 0);
        check("busy_cycles", n, exp_cycles);
        check("end_mode_clear", flush_mode, 0);
        check("end_dirty_clear", flush_dirty, 0);
        check("pending_wr", exp_wr.size(), 0);
        check("pending_rd", exp_rd.size(), 0);
        check("pending_fill", exp_fill.size(), 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctrl"}, {flush_mode, flush_write, flush_dirty, flush_addr,
                               line_in_valid, flush_busy, mem_wrreq, mem_rdreq}, 0);
        check({tag, "_line_in"}, line_in, 0);
        check({tag, "_mem_addr"}, mem_addr, 0);
        check({tag, "_mem_out"}, mem_out, 0);
    endtask

    initial begin
        int n;
        int busy_seen;
        reset_n        = 1'b0;
        dcache_addr    = '0;
        dcache_rdreq   = 1'b0;
        dcache_wrreq   = 1'b0;
        line_miss_all  = '1;
        line_valid_all = '0;
        line_dirty_all = '0;
        cnt_miss_all   = '0;
        line_addr_all  = {32'h0000_3000, 32'h0000_8000, 32'h0000_6000, 32'h0000_5000};
        mem_ack        = 1'b0;
        mem_in         = '0;
        mem_in_valid   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        reset_n = 1'b1;

        // Clean refill into invalid line 0.
        push_fill(32'h0000_1234);
        run_miss(1'b1, 1'b0, 32'h0000_1234, 4'b0001, 1'b0, 98);

        // Victim by miss count {3,9,9,1}: tie goes to line 1.
        line_valid_all = '1;
        cnt_miss_all   = {8'd1, 8'd9, 8'd9, 8'd3};
        push_fill(32'h0000_4000);
        run_miss(1'b0, 1'b1, 32'h0000_4000, 4'b0010, 1'b1, 98);

        // Dirty write-back of line 2, immediate ack.
        cnt_miss_all   = {8'd0, 8'd5, 8'd0, 8'd0};
        line_dirty_all = 4'b0100;
        push_wb(32'h0000_8000);
        push_fill(32'h0000_2000);
        run_miss(1'b1, 1'b0, 32'h0000_2000, 4'b0100, 1'b0, 1 + 32*2 + 32*3 + 1);

        // Same write-back with 5 extra cycles of ack back-pressure per word.
        ack_delay = 5;
        push_wb(32'h0000_8000);
        push_fill(32'h0000_2000);
        run_miss(1'b1, 1'b0, 32'h0000_2000, 4'b0100, 1'b0, 1 + 32*7 + 32*3 + 1);
        ack_delay = 0;

        // Reset during the refill, after the 10th word.
        line_valid_all = '0;
        line_dirty_all = '0;
        cur_mode       = 4'b0001;
        push_fill(32'h0000_1234);
        launch(1'b1, 1'b0, 32'h0000_1234);
        n = 0;
        while (fill_cnt < 10 && n < 1000) begin
            @(posedge clk);
            n++;
        end
        check("tenth_word_reached", (fill_cnt >= 10), 1);
        @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        check_all_zero("midreset");
        @(negedge clk);
        reset_n = 1'b1;
        exp_rd.delete();
        exp_fill.delete();
        push_fill(32'h0000_1234);
        run_miss(1'b1, 1'b0, 32'h0000_1234, 4'b0001, 1'b0, 98);

        // Hit: one line does not miss, nothing must happen.
        @(negedge clk);
        line_miss_all = 4'b1011;
        dcache_addr   = 32'h0000_1234;
        dcache_rdreq  = 1'b1;
        busy_seen     = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (flush_busy || mem_rdreq || mem_wrreq) busy_seen++;
        end
        check("hit_no_activity", busy_seen, 0);
        dcache_rdreq  = 1'b0;
        line_miss_all = '1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
